serializer_16_1: RTL and testbench
==================================

SERIALIZER_16_1 -- requirements
Module: serializer_16_1

Interface
REQ-001 SHALL: DATA_W, 16, width of each lane word.
REQ-002 SHALL: LANES, 16, number of lanes per frame; fixed at 16 so out_sel is 4 bits.
REQ-003 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL: in_data_1 .. in_data_16  input  DATA_W each  parallel frame; lane k is in_data_k.
REQ-006 SHALL: in_valid  input  1  frame present on in_data_*.
REQ-007 SHALL: in_ready  output  1  block accepts a frame this cycle.
REQ-008 SHALL: out_data  output  DATA_W  current serial word.
REQ-009 SHALL: out_sel  output  4  lane index of out_data, 4'b0000 = lane 1 ... 4'b1111 = lane 16; matches downstream demux select encoding.
REQ-010 SHALL: out_valid  output  1  out_data/out_sel valid.
REQ-011 SHALL: out_ready  input  1  downstream accepts word.
REQ-012 SHALL: out_last  output  1  present only with SER_LAST_EN; marks lane 16.

Function
REQ-013 SHALL: two-state FSM, IDLE and SHIFT.
REQ-014 SHALL: in IDLE, in_ready=1, out_valid=0, out_data=0, out_sel=0.
REQ-015 SHALL: a frame is accepted on in_valid&&in_ready; all 16 lanes captured into the lane register bank the same edge; index reset to 0; state -> SHIFT.
REQ-016 SHALL: in SHIFT, out_valid=1, out_data=bank[index], out_sel=index (combinational from registers).
REQ-017 SHALL: a word transfers on out_valid&&out_ready; index increments by 1 per transfer; no change while out_ready=0 (out_data/out_sel held stable).
REQ-018 SHALL: transfer at index 15 ends the frame: state -> IDLE unless a new frame is accepted the same cycle.
REQ-019 SHALL: in SHIFT, in_ready = (index==15) && out_ready, allowing back-to-back frames with zero bubble; on that simultaneous event the new frame loads, index -> 0, state stays SHIFT.
REQ-020 SHALL: in_valid while in_ready=0 has no effect; bank never overwritten mid-frame.
REQ-021 SHALL: latency from frame acceptance to first out_valid is exactly 1 cycle; one frame occupies 16 transfer cycles at full throughput.
REQ-022 SHALL: index is 4 bits and never wraps except via REQ-018/REQ-019.

Reset
REQ-023 SHALL: rst_n low asynchronously forces state=IDLE, index=0, bank=all zero, out_valid=0, out_last=0, in_ready=1 after release.
REQ-024 SHALL: reset mid-frame discards remaining words; no partial frame resumes.

Configuration
REQ-025 SHALL: macro SER_LAST_EN defined: out_last port exists and equals out_valid && (index==15).
REQ-026 SHALL: SER_LAST_EN undefined: out_last port and its logic absent; all other behaviour identical.

Structure
REQ-027 SHALL: shared package autoenc_pkg holds DATA_W and LANES constants and the serializer state typedef (IDLE, SHIFT).
REQ-028 SHALL: one sub-module mux_16_1 (16 x DATA_W inputs, 4-bit select, DATA_W output, purely combinational) selects bank[index].

Verification
REQ-029 SHALL: reset, frame lanes 16'h0001..16'h0010, out_ready=1 -> out_valid rises 1 cycle later, out_data 16'h0001..16'h0010 with out_sel 0..15 on consecutive cycles, then IDLE.
REQ-030 SHALL: same frame, out_ready toggled 1/0 every cycle -> each word held while out_ready=0, 16 transfers in 32 cycles, no word lost or duplicated.
REQ-031 SHALL: two frames (16'hA000+k, 16'hB000+k) with in_valid held high -> second accepted on the index-15 transfer cycle, 32 consecutive words, no idle cycle between.
REQ-032 SHALL: in_valid pulsed with new data at index 5 -> ignored, in_ready=0, original words continue.
REQ-033 SHALL: rst_n asserted at index 7 -> out_valid=0 immediately, after release in_ready=1, out_sel=0.
REQ-034 SHALL: with SER_LAST_EN, out_last=1 only with out_sel=4'b1111 and out_valid=1; build without macro compiles and passes REQ-029..REQ-033.

Source files
------------

// File: rtl/autoenc_pkg.sv
// Shared constants and types for the 16:1 frame serializer.
// Holds the lane word width, lane count, select width and the FSM state type.
package autoenc_pkg;

    localparam int DATA_W = 16;
    localparam int LANES  = 16;
    localparam int SEL_W  = $clog2(LANES);

    // Index of the final lane; a transfer here closes the frame.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LANES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/mux_16_1.sv
// Purely combinational 16:1 word selector.
// Picks one DATA_W word out of the packed lane bank using a 4-bit select.
module mux_16_1
    import autoenc_pkg::*;
(
    input  logic [LANES-1:0][DATA_W-1:0] in_words,
    input  logic [SEL_W-1:0]             sel,
    output logic [DATA_W-1:0]            out_word
);

    // Select the addressed lane word.
    always_comb begin
        out_word = in_words[sel];
    end

endmodule

// File: rtl/serializer_16_1.sv
// 16:1 frame serializer: captures a 16-lane parallel frame and emits it one
// word per accepted transfer, lane 1 first, with zero-bubble back-to-back
// frames when the last word and the next frame coincide.
// Optional feature: define SER_LAST_EN to add the out_last port, which flags
// the lane-16 word.
module serializer_16_1
    import autoenc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_data_3,
    input  logic [DATA_W-1:0] in_data_4,
    input  logic [DATA_W-1:0] in_data_5,
    input  logic [DATA_W-1:0] in_data_6,
    input  logic [DATA_W-1:0] in_data_7,
    input  logic [DATA_W-1:0] in_data_8,
    input  logic [DATA_W-1:0] in_data_9,
    input  logic [DATA_W-1:0] in_data_10,
    input  logic [DATA_W-1:0] in_data_11,
    input  logic [DATA_W-1:0] in_data_12,
    input  logic [DATA_W-1:0] in_data_13,
    input  logic [DATA_W-1:0] in_data_14,
    input  logic [DATA_W-1:0] in_data_15,
    input  logic [DATA_W-1:0] in_data_16,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SER_LAST_EN
    ,
    output logic              out_last
`endif
);

    ser_state_e                   state_q, state_d;
    logic [SEL_W-1:0]             index_q, index_d;
    logic [LANES-1:0][DATA_W-1:0] bank_q, bank_d;
    logic [LANES-1:0][DATA_W-1:0] lane_in;
    logic [DATA_W-1:0]            mux_word;
    logic                         accept;
    logic                         xfer;

    // Lane 1 sits at bank index 0 so out_sel maps directly onto the bank.
    assign lane_in = {in_data_16, in_data_15, in_data_14, in_data_13,
                      in_data_12, in_data_11, in_data_10, in_data_9,
                      in_data_8,  in_data_7,  in_data_6,  in_data_5,
                      in_data_4,  in_data_3,  in_data_2,  in_data_1};

    mux_16_1 u_mux (
        .in_words (bank_q),
        .sel      (index_q),
        .out_word (mux_word)
    );

    // Handshake outputs and next-state: load a frame or step through lanes.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        state_d   = state_q;
        index_d   = index_q;
        bank_d    = bank_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sel   = '0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_data  = mux_word;
                out_sel   = index_q;
                // The next frame may load only as the last word leaves.
                in_ready  = (index_q == LAST_IDX) && out_ready;
            end
        endcase

        accept = in_valid && in_ready;
        xfer   = out_valid && out_ready;

        if (accept) begin
            // Covers both a fresh frame from IDLE and the zero-bubble
            // reload on the final transfer of the current frame.
            bank_d  = lane_in;
            index_d = '0;
            state_d = SHIFT;
        end else if (xfer) begin
            if (index_q == LAST_IDX) begin
                index_d = '0;
                state_d = IDLE;
            end else begin
                index_d = index_q + 1'b1;
            end
        end
    end

    // State, lane index and lane bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the lane bank is cleared on reset on purpose, so no
            // stale frame data survives a reset; a bank that is only read
            // after a load would not strictly need it.
            state_q <= IDLE;
            index_q <= '0;
            bank_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge value of its neighbours.
            state_q <= state_d;
            index_q <= index_d;
            bank_q  <= bank_d;
        end
    end

`ifdef SER_LAST_EN
    assign out_last = out_valid && (index_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_serializer_16_1.sv
// Self-checking bench for serializer_16_1: a table-driven single frame,
// hand-written backpressure / back-to-back / ignored-frame / reset sequences,
// and randomized traffic compared against a word-queue reference model.
// Define SER_LAST_EN to also check out_last.
module tb_serializer_16_1;
    import autoenc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] lanes [LANES];
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;
    logic              out_valid;
    logic              out_ready;
`ifdef SER_LAST_EN
    logic              out_last;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic              iv;
        logic              ordy;
        logic              ir;
        logic              ov;
        logic [DATA_W-1:0] d;
        logic [SEL_W-1:0]  s;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [SEL_W-1:0]  s;
    } word_t;

    vec_t  vt [18];
    word_t q [$];

    always #5 clk = ~clk;

    serializer_16_1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_1  (lanes[0]),
        .in_data_2  (lanes[1]),
        .in_data_3  (lanes[2]),
        .in_data_4  (lanes[3]),
        .in_data_5  (lanes[4]),
        .in_data_6  (lanes[5]),
        .in_data_7  (lanes[6]),
        .in_data_8  (lanes[7]),
        .in_data_9  (lanes[8]),
        .in_data_10 (lanes[9]),
        .in_data_11 (lanes[10]),
        .in_data_12 (lanes[11]),
        .in_data_13 (lanes[12]),
        .in_data_14 (lanes[13]),
        .in_data_15 (lanes[14]),
        .in_data_16 (lanes[15]),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef SER_LAST_EN
        ,
        .out_last   (out_last)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ir, input logic ov,
                              input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s);
        check({tag, " in_ready"},  32'(in_ready),  32'(ir));
        check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, " out_data"},  32'(out_data),  32'(d));
        check({tag, " out_sel"},   32'(out_sel),   32'(s));
`ifdef SER_LAST_EN
        check({tag, " out_last"},  32'(out_last),  32'(ov && (s == 4'hF)));
`endif
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2
    // units later, well clear of either edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [DATA_W-1:0] base);
        for (int k = 0; k < LANES; k++) lanes[k] = base + DATA_W'(k + 1);
    endtask

    // Present a frame and let it be accepted from IDLE.
    task automatic load_frame(input logic [DATA_W-1:0] base);
        set_lanes(base);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        check_outs("load", 1'b1, 1'b0, '0, '0);
        next_cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_lanes('0);

        // Reset state, observed while reset is held.
        #12;
        check_outs("reset", 1'b1, 1'b0, '0, '0);
        rst_n = 1'b1;
        next_cycle();

        // Single frame 1..16 at full throughput, from a vector table.
        vt[0] = '{iv: 1'b1, ordy: 1'b1, ir: 1'b1, ov: 1'b0, d: '0, s: '0};
        for (int k = 1; k <= 16; k++)
            vt[k] = '{iv: 1'b0, ordy: 1'b1, ir: (k == 16), ov: 1'b1,
                      d: DATA_W'(k), s: SEL_W'(k - 1)};
        vt[17] = '{iv: 1'b0, ordy: 1'b1, ir: 1'b1, ov: 1'b0, d: '0, s: '0};
        set_lanes('0);
        for (int i = 0; i < 18; i++) begin
            in_valid  = vt[i].iv;
            out_ready = vt[i].ordy;
            #2;
            check_outs($sformatf("table[%0d]", i), vt[i].ir, vt[i].ov, vt[i].d, vt[i].s);
            next_cycle();
        end

        // Backpressure: out_ready alternates, each word held while stalled.
        load_frame('0);
        for (int j = 0; j < 32; j++) begin
            out_ready = (j % 2 == 1);
            #2;
            check_outs($sformatf("stall[%0d]", j), (j / 2 == 15) && out_ready, 1'b1,
                       DATA_W'(j / 2 + 1), SEL_W'(j / 2));
            next_cycle();
        end
        #2;
        check_outs("stall_end", 1'b1, 1'b0, '0, '0);
        next_cycle();

        // Back-to-back frames with in_valid held: 32 words, no bubble.
        load_frame(16'hA000);
        in_valid = 1'b1;
        set_lanes(16'hB000);
        for (int j = 0; j < 32; j++) begin
            if (j == 16) in_valid = 1'b0;
            #2;
            check_outs($sformatf("b2b[%0d]", j), (j % 16 == 15), 1'b1,
                       (j < 16) ? DATA_W'(16'hA000 + j + 1) : DATA_W'(16'hB000 + j - 15),
                       SEL_W'(j % 16));
            next_cycle();
        end
        #2;
        check_outs("b2b_end", 1'b1, 1'b0, '0, '0);
        next_cycle();

        // A frame offered mid-frame (index 5) is ignored.
        load_frame('0);
        for (int j = 0; j < 16; j++) begin
            if (j == 5) begin
                in_valid = 1'b1;
                for (int k = 0; k < LANES; k++) lanes[k] = 16'hDEAD;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            check_outs($sformatf("ignore[%0d]", j), (j == 15), 1'b1,
                       DATA_W'(j + 1), SEL_W'(j));
            next_cycle();
        end
        #2;
        check_outs("ignore_end", 1'b1, 1'b0, '0, '0);
        next_cycle();

        // Reset asserted at index 7 discards the rest of the frame.
        load_frame(16'h0100);
        for (int j = 0; j < 7; j++) next_cycle();
        #2;
        check_outs("pre_reset", 1'b0, 1'b1, 16'h0108, 4'd7);
        rst_n = 1'b0;
        #1;
        check("mid_reset out_valid", 32'(out_valid), 32'd0);
        check("mid_reset out_sel", 32'(out_sel), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check_outs("post_reset", 1'b1, 1'b0, '0, '0);
        next_cycle();
        #2;
        check_outs("post_reset_idle", 1'b1, 1'b0, '0, '0);
        next_cycle();
        load_frame(16'h0050);
        #2;
        check_outs("fresh_first", 1'b0, 1'b1, 16'h0051, 4'd0);
        for (int j = 0; j < 16; j++) next_cycle();
        #2;
        check_outs("fresh_end", 1'b1, 1'b0, '0, '0);
        next_cycle();

        // Randomized traffic against a queue-of-words reference model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            logic              e_ov;
            logic              e_ir;
            logic [DATA_W-1:0] e_d;
            logic [SEL_W-1:0]  e_s;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            for (int k = 0; k < LANES; k++) lanes[k] = DATA_W'($urandom);
            #2;
            e_ov = (q.size() > 0);
            e_ir = (q.size() == 0) || ((q.size() == 1) && out_ready);
            e_d  = e_ov ? q[0].d : '0;
            e_s  = e_ov ? q[0].s : '0;
            check_outs($sformatf("rand[%0d]", c), e_ir, e_ov, e_d, e_s);
            if (e_ov && out_ready) void'(q.pop_front());
            if (in_valid && e_ir)
                for (int k = 0; k < LANES; k++) q.push_back('{d: lanes[k], s: SEL_W'(k)});
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
